calc2_port_responder: RTL and testbench

- Single-port responder for the calc2 request/response protocol; it is the device end of what the calc2 benches drive.
- Captures two-cycle requests (cmd + operand1, then operand2), queues them in order and executes add/sub/shl/shr.
- Returns one tagged response per request.
- Serves as a reference/behavioural responder, and as the building block for a multi-port calc2 engine.

---
 rtl/calc2_port_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_calc2_port_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/calc2_port_responder.sv
// calc2 single-port responder: captures two-cycle requests, queues them in order,
// executes add/sub/shl/shr and returns one tagged response per accepted request.
module calc2_port_responder #(
  parameter int DATA_W  = 32,
  parameter int QDEPTH  = 4,
  parameter int ADD_LAT = 2,
  parameter int SHF_LAT = 3
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [1:0]        req_tag_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic              busy,
  output logic              err_tag_reuse
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_t;
  typedef enum logic [1:0] {EX_IDLE, EX_RUN, EX_RESP} ex_state_t;

  cap_state_t cap_state, cap_next;
  ex_state_t  ex_state, ex_next;

  logic [3:0]        cap_cmd;
  logic [DATA_W-1:0] cap_op1;
  logic [1:0]        cap_tag;
  logic              cap_drop;
  logic              cap_take, push, tag_hit;

  logic [3:0]        q_cmd [QDEPTH];
  logic [DATA_W-1:0] q_op1 [QDEPTH];
  logic [DATA_W-1:0] q_op2 [QDEPTH];
  logic [1:0]        q_tag [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     q_count;
  logic              q_empty, q_full;

  logic [3:0]        ex_cmd;
  logic [DATA_W-1:0] ex_op1, ex_op2;
  logic [1:0]        ex_tag;
  logic [7:0]        ex_cnt, head_lat;
  logic              pop, finish, clear;

  logic [DATA_W:0]   sum;
  logic [1:0]        res_resp;
  logic [DATA_W-1:0] res_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_empty = (q_count == '0);
  assign q_full  = (q_count == CW'(QDEPTH));
  assign busy    = !q_empty || (ex_state != EX_IDLE);

  // A tag is in flight while pending in capture, in any queue slot, or in execute.
  always_comb begin
    tag_hit = 1'b0;
    for (int unsigned i = 0; i < QDEPTH; i++)
      if (q_vld[i] && q_tag[i] == req_tag_in) tag_hit = 1'b1;
    if (ex_state != EX_IDLE && ex_tag == req_tag_in) tag_hit = 1'b1;
    if (cap_state == CAP_OP2 && !cap_drop && cap_tag == req_tag_in) tag_hit = 1'b1;
  end

  always_comb begin
    cap_next = cap_state;
    cap_take = 1'b0;
    push     = 1'b0;
    case (cap_state)
      CAP_IDLE: if (req_cmd_in != '0) begin
        cap_take = 1'b1;
        cap_next = CAP_OP2;
      end
      CAP_OP2: begin
        push     = !cap_drop && !q_full;
        cap_next = CAP_IDLE;
      end
      default: cap_next = CAP_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      cap_state     <= CAP_IDLE;
      cap_drop      <= 1'b0;
      err_tag_reuse <= 1'b0;
    end else begin
      cap_state <= cap_next;
      if (cap_take) begin
        cap_drop <= tag_hit;
        if (tag_hit) err_tag_reuse <= 1'b1;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (cap_take) begin
      cap_cmd <= req_cmd_in;
      cap_op1 <= req_data_in;
      cap_tag <= req_tag_in;
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      q_vld   <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= ptr_inc(rd_ptr);
        q_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= ptr_inc(wr_ptr);
        q_vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (push) begin
      q_cmd[wr_ptr] <= cap_cmd;
      q_op1[wr_ptr] <= cap_op1;
      q_op2[wr_ptr] <= req_data_in;
      q_tag[wr_ptr] <= cap_tag;
    end
  end

  assign head_lat = (q_cmd[rd_ptr] == 4'd5 || q_cmd[rd_ptr] == 4'd6) ? 8'(SHF_LAT) : 8'(ADD_LAT);

  // Result is registered on the edge where the count would step down to 1.
  always_comb begin
    ex_next = ex_state;
    pop     = 1'b0;
    finish  = 1'b0;
    clear   = 1'b0;
    case (ex_state)
      EX_IDLE: if (!q_empty) begin
        pop     = 1'b1;
        ex_next = EX_RUN;
      end
      EX_RUN: if (ex_cnt <= 8'd2) begin
        finish  = 1'b1;
        ex_next = EX_RESP;
      end
      EX_RESP: begin
        clear = 1'b1;
        if (!q_empty) begin
          pop     = 1'b1;
          ex_next = EX_RUN;
        end else begin
          ex_next = EX_IDLE;
        end
      end
      default: ex_next = EX_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset) ex_state <= EX_IDLE;
    else        ex_state <= ex_next;
  end

  always_ff @(posedge c_clk) begin
    if (pop) begin
      ex_cmd <= q_cmd[rd_ptr];
      ex_op1 <= q_op1[rd_ptr];
      ex_op2 <= q_op2[rd_ptr];
      ex_tag <= q_tag[rd_ptr];
      ex_cnt <= head_lat;
    end else if (ex_state == EX_RUN && !finish) begin
      ex_cnt <= ex_cnt - 1'b1;
    end
  end

  always_comb begin
    sum      = {1'b0, ex_op1} + {1'b0, ex_op2};
    res_resp = 2'd2;
    res_data = '0;
    case (ex_cmd)
      4'd1: if (!sum[DATA_W]) begin
        res_resp = 2'd1;
        res_data = sum[DATA_W-1:0];
      end
      4'd2: if (ex_op2 <= ex_op1) begin
        res_resp = 2'd1;
        res_data = ex_op1 - ex_op2;
      end
      4'd5: begin
        res_resp = 2'd1;
        res_data = ex_op1 << ex_op2[4:0];
      end
      4'd6: begin
        res_resp = 2'd1;
        res_data = ex_op1 >> ex_op2[4:0];
      end
      default: begin
        res_resp = 2'd2;
        res_data = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset || clear) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (finish) begin
      out_resp <= res_resp;
      out_data <= res_data;
      out_tag  <= ex_tag;
    end
  end

endmodule

// File: tb/tb_calc2_port_responder.sv
// Directed self-checking bench for calc2_port_responder (ADD_LAT=2, SHF_LAT=3).
module tb_calc2_port_responder;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        busy;
  logic        err_tag_reuse;

  int unsigned pass_count = 0;
  int unsigned fail_count = 0;
  int unsigned total_count = 0;

  calc2_port_responder #(
    .DATA_W (32),
    .QDEPTH (4),
    .ADD_LAT(2),
    .SHF_LAT(3)
  ) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_cmd_in   (req_cmd_in),
    .req_data_in  (req_data_in),
    .req_tag_in   (req_tag_in),
    .out_resp     (out_resp),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .busy         (busy),
    .err_tag_reuse(err_tag_reuse)
  );

  always #5 c_clk = ~c_clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [1:0] tag);
    @(negedge c_clk);
    req_cmd_in  = cmd;
    req_data_in = op1;
    req_tag_in  = tag;
    @(negedge c_clk);
    req_cmd_in  = '0;
    req_data_in = op2;
    req_tag_in  = '0;
  endtask

  // Sends one request from idle and checks exact response timing and contents.
  task automatic single(input string name, input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [1:0] tag, input int lat,
                        input logic [1:0] exp_resp, input logic [31:0] exp_data);
    send(cmd, op1, op2, tag);
    @(negedge c_clk);
    idle_inputs();
    repeat (lat - 1) @(negedge c_clk);
    check({name, "_pre_resp"}, 64'(out_resp), 64'(2'd0));
    check({name, "_pre_busy"}, 64'(busy), 64'(1'b1));
    @(negedge c_clk);
    check({name, "_resp"}, 64'(out_resp), 64'(exp_resp));
    check({name, "_data"}, 64'(out_data), 64'(exp_data));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    @(negedge c_clk);
    check({name, "_post"}, {27'd0, out_resp, out_data, out_tag, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  er;
    logic [31:0] ed;
    logic [1:0]  et;
    logic        eb;

    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge c_clk);
    check("rst_resp", 64'(out_resp), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_tag_reuse), 64'd0);
    reset = 1'b1;

    single("add", 4'd1, 32'h30, 32'h20, 2'd1, 2, 2'd1, 32'h50);
    single("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 2, 2'd2, 32'h0);
    single("sub_neg", 4'd2, 32'h10, 32'h20, 2'd3, 2, 2'd2, 32'h0);
    single("sub_eq", 4'd2, 32'h20, 32'h20, 2'd0, 2, 2'd1, 32'h0);
    single("shl", 4'd5, 32'h1, 32'h4, 2'd1, 3, 2'd1, 32'h10);
    single("shr", 4'd6, 32'h8000_0000, 32'd31, 2'd2, 3, 2'd1, 32'h1);

    // Four back-to-back requests; first cmd captured at the edge after i=0.
    for (int i = 0; i < 16; i++) begin
      @(negedge c_clk);
      er = '0; ed = '0; et = '0;
      case (i)
        4:  begin er = 2'd1; ed = 32'hC;   et = 2'd0; end
        7:  begin er = 2'd1; ed = 32'hF00; et = 2'd1; end
        9:  begin er = 2'd1; ed = 32'hFF;  et = 2'd2; end
        11: begin er = 2'd2; ed = 32'h0;   et = 2'd3; end
        default: ;
      endcase
      eb = (i >= 2 && i <= 11);
      check($sformatf("queue_n%0d", i), {27'd0, out_resp, out_data, out_tag, eb ? busy : busy},
            {27'd0, er, ed, et, eb});
      idle_inputs();
      case (i)
        0: begin req_cmd_in = 4'd1; req_data_in = 32'h5;   req_tag_in = 2'd0; end
        1: req_data_in = 32'h7;
        2: begin req_cmd_in = 4'd5; req_data_in = 32'hF;   req_tag_in = 2'd1; end
        3: req_data_in = 32'h8;
        4: begin req_cmd_in = 4'd2; req_data_in = 32'h100; req_tag_in = 2'd2; end
        5: req_data_in = 32'h1;
        6: begin req_cmd_in = 4'd3; req_data_in = 32'hAB;  req_tag_in = 2'd3; end
        7: req_data_in = 32'hCD;
        default: ;
      endcase
    end
    check("queue_err", 64'(err_tag_reuse), 64'd0);

    // Tag 1 issued again while the first tag-1 request is still queued.
    for (int i = 0; i < 10; i++) begin
      @(negedge c_clk);
      er = '0; ed = '0; et = '0;
      if (i == 5) begin er = 2'd1; ed = 32'h6; et = 2'd1; end
      eb = (i >= 2 && i <= 5);
      check($sformatf("reuse_n%0d", i), {27'd0, out_resp, out_data, out_tag, busy},
            {27'd0, er, ed, et, eb});
      idle_inputs();
      case (i)
        0: begin req_cmd_in = 4'd5; req_data_in = 32'h3; req_tag_in = 2'd1; end
        1: req_data_in = 32'h1;
        2: begin req_cmd_in = 4'd1; req_data_in = 32'h9; req_tag_in = 2'd1; end
        3: req_data_in = 32'h9;
        default: ;
      endcase
    end
    check("reuse_err", 64'(err_tag_reuse), 64'd1);

    // Reset lands on the edge that would have registered the add result.
    send(4'd1, 32'h1, 32'h2, 2'd0);
    @(negedge c_clk);
    idle_inputs();
    @(negedge c_clk);
    reset = 1'b0;
    @(negedge c_clk);
    reset = 1'b1;
    check("midrst_outs", {27'd0, out_resp, out_data, out_tag, busy}, 64'd0);
    check("midrst_err", 64'(err_tag_reuse), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge c_clk);
      check($sformatf("midrst_quiet%0d", i), {27'd0, out_resp, out_data, out_tag, busy}, 64'd0);
    end
    single("post_rst_add", 4'd1, 32'h1, 32'h1, 2'd3, 2, 2'd1, 32'h2);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
